// File: rtl/tile_pixel_fetch_if.sv
// Bus bundle for tile_pixel_fetch: character request handshake, tile BRAM
// read port and the pixel strobe/output group.
interface tile_pixel_fetch_if #(
   parameter int AWIDTH = 12
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic [AWIDTH-1:0] tile_base_i;
   logic [7:0]        tile_index_i;
   logic [3:0]        tile_row_i;
   logic [7:0]        attr_i;
   logic [AWIDTH-1:0] rd_address_o;
   logic [15:0]       rd_data_i;
   logic              pix_en_i;
   logic [3:0]        pixel_o;
   logic              pixel_valid_o;
   logic              underflow_o;

   modport master (
      output req_valid_i, tile_base_i, tile_index_i, tile_row_i, attr_i,
             rd_data_i, pix_en_i,
      input  req_ready_o, rd_address_o, pixel_o, pixel_valid_o, underflow_o
   );

   modport slave (
      input  req_valid_i, tile_base_i, tile_index_i, tile_row_i, attr_i,
             rd_data_i, pix_en_i,
      output req_ready_o, rd_address_o, pixel_o, pixel_valid_o, underflow_o
   );
endinterface

// File: rtl/tile_pixel_fetch.sv
// Text-mode pixel generator: fetches one font word per character request and
// serialises it into 4-bit colour indices. Define TILE_PIXEL_HDOUBLE_EN to emit every glyph bit twice.
module tile_pixel_fetch #(
   parameter int AWIDTH   = 12,
   parameter int TILE_H16 = 1
) (
   input  logic             clk,
   input  logic             reset_i,
   tile_pixel_fetch_if.slave bus
);

   typedef logic [AWIDTH-1:0] addr_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      CAPT = 2'd2
   } fetch_state_t;

   function automatic addr_t calc_addr(input addr_t base, input logic [7:0] idx,
                                       input logic [2:0] row_hi);
      if (TILE_H16 != 0)
         return base + addr_t'({idx, 3'b000}) + addr_t'(row_hi);
      else
         return base + addr_t'({idx, 2'b00}) + addr_t'(row_hi[1:0]);
   endfunction

   function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic lo);
      return lo ? word[7:0] : word[15:8];
   endfunction

   function automatic logic [3:0] pick_pixel(input logic bit_v, input logic [7:0] attr);
      return bit_v ? attr[3:0] : attr[7:4];
   endfunction

   fetch_state_t state, state_nxt;
   logic         accept;
   logic         capt;
   logic         req_ready;

   addr_t        rd_addr_p0;
   logic         sel_p0;
   logic [7:0]   attr_p0;

   logic         vld_p1;
   logic [7:0]   buf_byte_p1;
   logic [7:0]   buf_attr_p1;

   logic [7:0]   sh_p2;
   logic [7:0]   attr_p2;
   logic [3:0]   cnt_p2;
   logic [3:0]   pix_p2;
   logic         vld_p2;
   logic         uf_p2;
`ifdef TILE_PIXEL_HDOUBLE_EN
   logic         sub_p2;
   logic         sub_nxt;
`endif

   logic         src_avail;
   logic [7:0]   src_byte;
   logic [7:0]   src_attr;
   logic         ld_empty;
   logic         ld_tail;
   logic         consume;
   logic [7:0]   eff_sh;
   logic [7:0]   eff_attr;
   logic [3:0]   eff_cnt;
   logic [7:0]   sh_nxt;
   logic [7:0]   attr_nxt;
   logic [3:0]   cnt_nxt;
   logic [3:0]   pix_nxt;
   logic         vld_nxt;
   logic         uf_nxt;

   always_ff @(posedge clk) begin
      if (reset_i)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // The holding buffer is always empty while a fetch is in flight, because
   // requests are only accepted with it empty.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capt      = 1'b0;
      req_ready = 1'b0;
      case (state)
         IDLE: begin
            req_ready = ~vld_p1 & ~reset_i;
            if (bus.req_valid_i && req_ready) begin
               accept    = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: state_nxt = CAPT;
         CAPT: begin
            capt      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---- stage p0: request latch / BRAM address ----
   always_ff @(posedge clk) begin
      if (reset_i)
         rd_addr_p0 <= '0;
      else if (accept)
         rd_addr_p0 <= calc_addr(bus.tile_base_i, bus.tile_index_i, bus.tile_row_i[3:1]);
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         sel_p0  <= bus.tile_row_i[0];
         attr_p0 <= bus.attr_i;
      end
   end

   // ---- stage p1: holding buffer (CAPT data forwarded when the buffer is empty) ----
   assign src_avail = vld_p1 | capt;
   assign src_byte  = vld_p1 ? buf_byte_p1 : sel_byte(bus.rd_data_i, sel_p0);
   assign src_attr  = vld_p1 ? buf_attr_p1 : attr_p0;

   always_ff @(posedge clk) begin
      if (reset_i)
         vld_p1 <= 1'b0;
      else if (capt && !consume)
         vld_p1 <= 1'b1;
      else if (consume)
         vld_p1 <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (capt) begin
         buf_byte_p1 <= sel_byte(bus.rd_data_i, sel_p0);
         buf_attr_p1 <= attr_p0;
      end
   end

   // ---- stage p2: shifter; an empty shifter loads first, a drained one reloads after the strobe ----
   always_comb begin
      ld_empty = (cnt_p2 == 4'd0) && src_avail;
      eff_sh   = ld_empty ? src_byte : sh_p2;
      eff_attr = ld_empty ? src_attr : attr_p2;
      eff_cnt  = ld_empty ? 4'd8 : cnt_p2;
      sh_nxt   = eff_sh;
      attr_nxt = eff_attr;
      cnt_nxt  = eff_cnt;
      pix_nxt  = pix_p2;
      vld_nxt  = 1'b0;
      uf_nxt   = 1'b0;
`ifdef TILE_PIXEL_HDOUBLE_EN
      sub_nxt  = sub_p2;
`endif
      if (bus.pix_en_i) begin
         if (eff_cnt != 4'd0) begin
            pix_nxt = pick_pixel(eff_sh[7], eff_attr);
            vld_nxt = 1'b1;
`ifdef TILE_PIXEL_HDOUBLE_EN
            if (sub_p2) begin
               sub_nxt = 1'b0;
               sh_nxt  = {eff_sh[6:0], 1'b0};
               cnt_nxt = eff_cnt - 4'd1;
            end else begin
               sub_nxt = 1'b1;
            end
`else
            sh_nxt  = {eff_sh[6:0], 1'b0};
            cnt_nxt = eff_cnt - 4'd1;
`endif
         end else begin
            pix_nxt = 4'd0;
            uf_nxt  = 1'b1;
         end
      end
      ld_tail = (cnt_nxt == 4'd0) && src_avail && !ld_empty;
      if (ld_tail) begin
         sh_nxt   = src_byte;
         attr_nxt = src_attr;
         cnt_nxt  = 4'd8;
      end
      consume = ld_empty | ld_tail;
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         cnt_p2 <= 4'd0;
         pix_p2 <= 4'd0;
         vld_p2 <= 1'b0;
         uf_p2  <= 1'b0;
`ifdef TILE_PIXEL_HDOUBLE_EN
         sub_p2 <= 1'b0;
`endif
      end else begin
         cnt_p2 <= cnt_nxt;
         pix_p2 <= pix_nxt;
         vld_p2 <= vld_nxt;
         uf_p2  <= uf_nxt;
`ifdef TILE_PIXEL_HDOUBLE_EN
         sub_p2 <= sub_nxt;
`endif
      end
   end

   always_ff @(posedge clk) begin
      sh_p2   <= sh_nxt;
      attr_p2 <= attr_nxt;
   end

   assign bus.req_ready_o   = req_ready;
   assign bus.rd_address_o  = rd_addr_p0;
   assign bus.pixel_o       = pix_p2;
   assign bus.pixel_valid_o = vld_p2;
   assign bus.underflow_o   = uf_p2;

endmodule

// File: tb/tb_tile_pixel_fetch.sv
// Bench for tile_pixel_fetch: 8x16 instance checked every cycle against a
// character/pixel-queue model, plus literal checks on both glyph heights.
module tb_tile_pixel_fetch;
   localparam int AW = 12;
`ifdef TILE_PIXEL_HDOUBLE_EN
   localparam int REP = 2;
`else
   localparam int REP = 1;
`endif

   logic clk = 1'b0;
   logic reset_i;
   always #5 clk = ~clk;

   tile_pixel_fetch_if #(.AWIDTH(AW)) if0 ();
   tile_pixel_fetch_if #(.AWIDTH(AW)) if1 ();

   tile_pixel_fetch #(.AWIDTH(AW), .TILE_H16(1)) u_dut16 (
      .clk(clk), .reset_i(reset_i), .bus(if0.slave));
   tile_pixel_fetch #(.AWIDTH(AW), .TILE_H16(0)) u_dut8 (
      .clk(clk), .reset_i(reset_i), .bus(if1.slave));

   logic [15:0] mem [4096];
   always @(posedge clk) begin
      if0.rd_data_i <= mem[if0.rd_address_o];
      if1.rd_data_i <= mem[if1.rd_address_o];
   end

   int n_checks = 0;
   int n_pass   = 0;
   bit started  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: characters in flight (cycle they become displayable), then a flat
   // pixel queue with per-character remaining counts.
   int          cyc = 0;
   int          f_rdy [$];
   logic [15:0] f_pay [$];
   int          act_left [$];
   logic [3:0]  pix_q [$];
   logic [11:0] m_addr = '0;
   logic [3:0]  m_pix = '0;
   logic        m_vld = 1'b0;
   logic        m_uf = 1'b0;

   always @(posedge clk) begin : model_p
      logic        acc;
      int          tmp;
      logic [11:0] a;
      logic [15:0] w;
      logic [7:0]  b;
      logic [7:0]  at;
      if (reset_i) begin
         f_rdy.delete(); f_pay.delete(); act_left.delete(); pix_q.delete();
         m_addr = '0; m_pix = '0; m_vld = 1'b0; m_uf = 1'b0;
      end else begin
         acc = if0.req_valid_i && f_rdy.size() == 0 && act_left.size() <= 1;
         if (acc) begin
            tmp = int'(if0.tile_base_i) + int'(if0.tile_index_i) * 8 + int'(if0.tile_row_i) / 2;
            a = tmp[11:0];
            w = mem[a];
            b = if0.tile_row_i[0] ? w[7:0] : w[15:8];
            f_rdy.push_back(cyc + 2);
            f_pay.push_back({if0.attr_i, b});
            m_addr = a;
         end
         while (f_rdy.size() > 0 && f_rdy[0] <= cyc) begin
            void'(f_rdy.pop_front());
            {at, b} = f_pay.pop_front();
            for (int bi = 7; bi >= 0; bi--)
               for (int r = 0; r < REP; r++)
                  pix_q.push_back(b[bi] ? at[3:0] : at[7:4]);
            act_left.push_back(8 * REP);
         end
         if (if0.pix_en_i) begin
            if (pix_q.size() > 0) begin
               m_pix = pix_q.pop_front();
               m_vld = 1'b1;
               m_uf  = 1'b0;
               act_left[0] = act_left[0] - 1;
               if (act_left[0] == 0) void'(act_left.pop_front());
            end else begin
               m_pix = 4'd0; m_vld = 1'b0; m_uf = 1'b1;
            end
         end else begin
            m_vld = 1'b0; m_uf = 1'b0;
         end
      end
      cyc++;
      #1;
      if (started) begin
         check("ready", 32'(if0.req_ready_o),
               32'(!reset_i && f_rdy.size() == 0 && act_left.size() <= 1));
         check("rd_address", 32'(if0.rd_address_o), 32'(m_addr));
         check("pixel", 32'(if0.pixel_o), 32'(m_pix));
         check("pixel_valid", 32'(if0.pixel_valid_o), 32'(m_vld));
         check("underflow", 32'(if0.underflow_o), 32'(m_uf));
      end
   end

   task automatic send0(input logic [11:0] base, input logic [7:0] idx,
                        input logic [3:0] row, input logic [7:0] attr);
      bit done = 1'b0;
      @(negedge clk);
      if0.req_valid_i = 1'b1; if0.tile_base_i = base; if0.tile_index_i = idx;
      if0.tile_row_i = row; if0.attr_i = attr;
      for (int i = 0; i < 40; i++) begin
         if (if0.req_ready_o) begin done = 1'b1; break; end
         @(negedge clk);
      end
      check("req_accept", 32'(done), 32'd1);
      if (done) @(negedge clk);
      if0.req_valid_i = 1'b0;
   endtask

   logic [3:0] got [16];
   logic [3:0] e_glyph [8];
   int vcount, ucount;

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 16'((i * 40503) ^ 23130);
      mem[12'h20A] = 16'h3C81;
      mem[12'h180] = 16'h0FFF;
      mem[12'h189] = 16'h5AF0;
      mem[12'h32B] = 16'h8011;
      mem[12'h005] = 16'hA53C;
      reset_i = 1'b1;
      if0.req_valid_i = 1'b0; if0.tile_base_i = '0; if0.tile_index_i = '0;
      if0.tile_row_i = '0; if0.attr_i = '0; if0.pix_en_i = 1'b0;
      if1.req_valid_i = 1'b0; if1.tile_base_i = '0; if1.tile_index_i = '0;
      if1.tile_row_i = '0; if1.attr_i = '0; if1.pix_en_i = 1'b0;

      @(posedge clk);
      started = 1'b1;
      @(posedge clk); #1;
      check("rst_pixel", 32'(if0.pixel_o), 32'd0);
      check("rst_valid", 32'(if0.pixel_valid_o), 32'd0);
      check("rst_underflow", 32'(if0.underflow_o), 32'd0);
      check("rst_addr", 32'(if0.rd_address_o), 32'd0);
      check("rst_ready", 32'(if0.req_ready_o), 32'd0);
      @(negedge clk) reset_i = 1'b0;
      @(posedge clk); #1;
      check("ready_after_reset", 32'(if0.req_ready_o), 32'd1);

      // No request ever issued: every strobe underflows
      @(negedge clk) if0.pix_en_i = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         check("idle_underflow", 32'(if0.underflow_o), 32'd1);
         check("idle_valid", 32'(if0.pixel_valid_o), 32'd0);
      end
      @(negedge clk) if0.pix_en_i = 1'b0;

      // 8x16 address and glyph byte 0x81, attr 0x1F
      send0(12'h000, 8'h41, 4'd5, 8'h1F);
      check("addr_8x16", 32'(if0.rd_address_o), 32'h20A);
      repeat (3) @(negedge clk);
      if0.pix_en_i = 1'b1;
      for (int k = 0; k < 8 * REP; k++) begin @(posedge clk); #1; got[k] = if0.pixel_o; end
      @(negedge clk) if0.pix_en_i = 1'b0;
      e_glyph = '{4'hF, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'hF};
      for (int k = 0; k < 8 * REP; k++) check("glyph_81", 32'(got[k]), 32'(e_glyph[k / REP]));

      // Two queued characters with the strobe held high
      send0(12'h100, 8'h10, 4'd0, 8'h34);
      send0(12'h100, 8'h11, 4'd3, 8'hC9);
      repeat (4) @(negedge clk);
      if0.pix_en_i = 1'b1;
      vcount = 0; ucount = 0;
      for (int k = 0; k < 16 * REP; k++) begin
         @(posedge clk); #1;
         got[k / REP] = if0.pixel_o;
         if (if0.pixel_valid_o) vcount++;
         if (if0.underflow_o) ucount++;
      end
      @(negedge clk) if0.pix_en_i = 1'b0;
      check("b2b_valid_count", 32'(vcount), 32'(16 * REP));
      check("b2b_underflow_count", 32'(ucount), 32'd0);
      check("b2b_last_of_first", 32'(got[7]), 32'h4);
      check("b2b_first_of_second", 32'(got[8]), 32'h9);

      // Reset while the fetch waits on the BRAM
      send0(12'h200, 8'h07, 4'd2, 8'hEE);
      reset_i = 1'b1;
      @(negedge clk) reset_i = 1'b0;
      @(negedge clk) if0.pix_en_i = 1'b1;
      vcount = 0;
      repeat (8 * REP + 4) begin
         @(posedge clk); #1;
         if (if0.pixel_valid_o) vcount++;
      end
      @(negedge clk) if0.pix_en_i = 1'b0;
      check("flushed_no_pixels", 32'(vcount), 32'd0);

      send0(12'h300, 8'h05, 4'd6, 8'h52);
      check("addr_after_reset", 32'(if0.rd_address_o), 32'h32B);
      repeat (3) @(negedge clk);
      if0.pix_en_i = 1'b1;
      for (int k = 0; k < 8 * REP; k++) begin @(posedge clk); #1; got[k] = if0.pixel_o; end
      @(negedge clk) if0.pix_en_i = 1'b0;
      e_glyph = '{4'h2, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5};
      for (int k = 0; k < 8 * REP; k++) check("glyph_80", 32'(got[k]), 32'(e_glyph[k / REP]));

      // 8x8 instance: address wraps, even row takes the high byte
      @(negedge clk);
      if1.req_valid_i = 1'b1; if1.tile_base_i = 12'hFFC; if1.tile_index_i = 8'h02;
      if1.tile_row_i = 4'd2; if1.attr_i = 8'h70;
      check("ready_8x8", 32'(if1.req_ready_o), 32'd1);
      @(negedge clk) if1.req_valid_i = 1'b0;
      check("addr_8x8_wrap", 32'(if1.rd_address_o), 32'h005);
      repeat (2) @(negedge clk);
      if1.pix_en_i = 1'b1;
      for (int k = 0; k < 8 * REP; k++) begin @(posedge clk); #1; got[k] = if1.pixel_o; end
      @(negedge clk) if1.pix_en_i = 1'b0;
      e_glyph = '{4'h0, 4'h7, 4'h0, 4'h7, 4'h7, 4'h0, 4'h7, 4'h0};
      for (int k = 0; k < 8 * REP; k++) check("glyph_8x8", 32'(got[k]), 32'(e_glyph[k / REP]));

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: run did not complete");
      $fatal(1);
   end
endmodule
